// File: rtl/evt_gen_pkg.sv
// evt_gen_pkg: shared types and defaults for the event-pulse generator
package evt_gen_pkg;
  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_DONE} state_e;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_TIM_W = 24;
  localparam int MIN_PERIOD = 2;
endpackage

// File: rtl/evt_gen_if.sv
// evt_gen_if: control and status bundle between a loader and the generator
interface evt_gen_if import evt_gen_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W,
  parameter int TIM_W = DEF_TIM_W
);
  logic start;
  logic abort;
  logic cont;
  logic [CNT_W-1:0] num_evt;
  logic [TIM_W-1:0] period;
  logic [TIM_W-1:0] width;
  logic evt_out;
  logic busy;
  logic done;
  logic [CNT_W-1:0] sent_count;
  modport master (output start, abort, cont, num_evt, period, width, input evt_out, busy, done, sent_count);
  modport slave (input start, abort, cont, num_evt, period, width, output evt_out, busy, done, sent_count);
endinterface

// File: rtl/evt_gen_timer.sv
// evt_timer: reloadable down-counter flagging once when it reaches zero
module evt_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         expire_o
);
  logic [W-1:0] cnt_q;
  logic armed_q;
  assign expire_o = armed_q && cnt_q == '0;
  // count down from the loaded value; the armed bit limits expiry to one cycle per load
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      armed_q <= 1'b0;
    end else begin
      cnt_q <= load_i ? val_i : (cnt_q != '0 ? cnt_q - W'(1) : cnt_q);
      armed_q <= load_i || (armed_q && !expire_o);
    end
  end
endmodule

// File: rtl/evt_gen.sv
// evt_gen: programmable event-pulse train generator
module evt_gen import evt_gen_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W,
  parameter int TIM_W = DEF_TIM_W
) (
  input logic clk,
  input logic rst,
  evt_gen_if.slave bus
);
  state_e state_q, state_d;
  logic [TIM_W-1:0] p_c, w_c, p_q, w_q, ld_val;
  logic [CNT_W-1:0] n_q, sent_q, sent_d;
  logic cont_q, accept, last, expire, ld;
  // clamp so every event has at least one high and one low cycle
  always_comb begin
    p_c = bus.period < TIM_W'(MIN_PERIOD) ? TIM_W'(MIN_PERIOD) : bus.period;
    w_c = bus.width == '0 ? TIM_W'(1) : (bus.width >= p_c ? p_c - TIM_W'(1) : bus.width);
  end
  // next state, timer reload and event count; the first reload uses the unlatched clamped width
  always_comb begin
    accept = state_q == S_IDLE && bus.start && !bus.abort;
    last = !cont_q && sent_q == n_q;
    state_d = state_q == S_IDLE ? (accept ? (!bus.cont && bus.num_evt == '0 ? S_DONE : S_HIGH) : S_IDLE) :
              (state_q == S_DONE || bus.abort) ? S_IDLE :
              !expire ? state_q :
              state_q == S_HIGH ? (last ? S_DONE : S_LOW) : S_HIGH;
    ld = state_d != state_q;
    ld_val = state_q == S_IDLE ? w_c - TIM_W'(1) :
             state_d == S_HIGH ? w_q - TIM_W'(1) : p_q - w_q - TIM_W'(1);
    sent_d = accept ? (state_d == S_HIGH ? CNT_W'(1) : '0) :
             (state_q == S_LOW && state_d == S_HIGH) ? sent_q + CNT_W'(1) : sent_q;
  end
  // state, count and the train parameters captured at an accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sent_q <= '0;
      p_q <= '0;
      w_q <= '0;
      n_q <= '0;
      cont_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sent_q <= sent_d;
      if (accept) begin
        p_q <= p_c;
        w_q <= w_c;
        n_q <= bus.num_evt;
        cont_q <= bus.cont;
      end
    end
  end
  evt_timer #(.W(TIM_W)) u_timer (
    .clk(clk),
    .rst(rst),
    .load_i(ld),
    .val_i(ld_val),
    .expire_o(expire)
  );
  assign bus.evt_out = state_q == S_HIGH;
  assign bus.busy = state_q == S_HIGH || state_q == S_LOW;
  assign bus.done = state_q == S_DONE;
  assign bus.sent_count = sent_q;
endmodule

// File: tb/tb_evt_gen.sv
// tb_evt_gen: scoreboard bench for the event-pulse generator
module tb_evt_gen;
  typedef struct packed {
    logic evt;
    logic busy;
    logic done;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  exp_t e;

  always #5 clk = ~clk;

  evt_gen_if #(.CNT_W(16), .TIM_W(24)) b1 ();
  evt_gen_if #(.CNT_W(4), .TIM_W(24)) b2 ();

  evt_gen #(.CNT_W(16), .TIM_W(24)) dut (.clk(clk), .rst(rst), .bus(b1));
  evt_gen #(.CNT_W(4), .TIM_W(24)) dut4 (.clk(clk), .rst(rst), .bus(b2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic ev, input logic bs, input logic dn, input int cnt);
    q.push_back('{ev, bs, dn, 16'(cnt)});
  endtask

  // expected waveform of a finite train, one entry per cycle from the cycle after start
  task automatic push_train(input int n, input int p, input int w);
    for (int k = 1; k <= n; k++) begin
      for (int i = 0; i < w; i++) push(1, 1, 0, k);
      if (k < n) for (int i = 0; i < p - w; i++) push(0, 1, 0, k);
    end
    push(0, 0, 1, n);
    push(0, 0, 0, n);
  endtask

  task automatic load1(input int n, input int p, input int w);
    b1.num_evt = 16'(n);
    b1.period = 24'(p);
    b1.width = 24'(w);
  endtask

  task automatic fire1();
    b1.start = 1;
    step();
    b1.start = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    step();
    step();
    push(0, 0, 0, 0);
    e = q.pop_front();
    checks++;
    if ({b1.evt_out, b1.busy, b1.done, b1.sent_count} !== e) begin
      errors++;
      $display("FAIL reset: got evt=%b busy=%b done=%b cnt=%0d want %b %b %b %0d", b1.evt_out, b1.busy, b1.done, b1.sent_count, e.evt, e.busy, e.done, e.cnt);
    end
    checks++;
    if ({b2.evt_out, b2.busy, b2.done, b2.sent_count} !== 7'b0) begin
      errors++;
      $display("FAIL reset4: got evt=%b busy=%b done=%b cnt=%0d want 0 0 0 0", b2.evt_out, b2.busy, b2.done, b2.sent_count);
    end
    rst = 0;
    step();
  endtask

  task automatic test_basic();
    int i = 0;
    load1(3, 5, 2);
    push_train(3, 5, 2);
    fire1();
    while (q.size() != 0) begin
      e = q.pop_front();
      checks++;
      if ({b1.evt_out, b1.busy, b1.done, b1.sent_count} !== e) begin
        errors++;
        $display("FAIL basic cyc%0d: got evt=%b busy=%b done=%b cnt=%0d want %b %b %b %0d", i, b1.evt_out, b1.busy, b1.done, b1.sent_count, e.evt, e.busy, e.done, e.cnt);
      end
      if (i == 3) begin
        b1.start = 1;
        load1(9, 3, 1);
      end
      step();
      b1.start = 0;
      i++;
    end
  endtask

  task automatic test_clamp(input int n, input int p, input int w, input int pe, input int we);
    int i = 0;
    load1(n, p, w);
    push_train(n, pe, we);
    fire1();
    load1(0, 0, 0);
    while (q.size() != 0) begin
      e = q.pop_front();
      checks++;
      if ({b1.evt_out, b1.busy, b1.done, b1.sent_count} !== e) begin
        errors++;
        $display("FAIL clamp p=%0d w=%0d cyc%0d: got evt=%b busy=%b done=%b cnt=%0d want %b %b %b %0d", p, w, i, b1.evt_out, b1.busy, b1.done, b1.sent_count, e.evt, e.busy, e.done, e.cnt);
      end
      step();
      i++;
    end
  endtask

  task automatic test_zero();
    int i = 0;
    load1(0, 5, 2);
    push_train(0, 5, 2);
    push(0, 0, 0, 0);
    fire1();
    while (q.size() != 0) begin
      e = q.pop_front();
      checks++;
      if ({b1.evt_out, b1.busy, b1.done, b1.sent_count} !== e) begin
        errors++;
        $display("FAIL zero cyc%0d: got evt=%b busy=%b done=%b cnt=%0d want %b %b %b %0d", i, b1.evt_out, b1.busy, b1.done, b1.sent_count, e.evt, e.busy, e.done, e.cnt);
      end
      step();
      i++;
    end
  endtask

  task automatic test_abort();
    load1(100, 4, 1);
    push_train(100, 4, 1);
    fire1();
    for (int i = 0; i < 25; i++) begin
      e = q.pop_front();
      checks++;
      if ({b1.evt_out, b1.busy, b1.done, b1.sent_count} !== e) begin
        errors++;
        $display("FAIL abort_run cyc%0d: got evt=%b busy=%b done=%b cnt=%0d want %b %b %b %0d", i, b1.evt_out, b1.busy, b1.done, b1.sent_count, e.evt, e.busy, e.done, e.cnt);
      end
      if (i == 24) b1.abort = 1;
      step();
    end
    b1.abort = 0;
    q.delete();
    repeat (3) push(0, 0, 0, 7);
    while (q.size() != 0) begin
      e = q.pop_front();
      checks++;
      if ({b1.evt_out, b1.busy, b1.done, b1.sent_count} !== e) begin
        errors++;
        $display("FAIL abort_idle: got evt=%b busy=%b done=%b cnt=%0d want %b %b %b %0d", b1.evt_out, b1.busy, b1.done, b1.sent_count, e.evt, e.busy, e.done, e.cnt);
      end
      step();
    end
  endtask

  task automatic test_start_abort();
    load1(3, 5, 2);
    b1.abort = 1;
    fire1();
    b1.abort = 0;
    repeat (3) push(0, 0, 0, 7);
    while (q.size() != 0) begin
      e = q.pop_front();
      checks++;
      if ({b1.evt_out, b1.busy, b1.done, b1.sent_count} !== e) begin
        errors++;
        $display("FAIL start_abort: got evt=%b busy=%b done=%b cnt=%0d want %b %b %b %0d", b1.evt_out, b1.busy, b1.done, b1.sent_count, e.evt, e.busy, e.done, e.cnt);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    load1(10, 6, 2);
    push_train(10, 6, 2);
    fire1();
    for (int i = 0; i < 4; i++) begin
      e = q.pop_front();
      checks++;
      if ({b1.evt_out, b1.busy, b1.done, b1.sent_count} !== e) begin
        errors++;
        $display("FAIL rst_mid_run cyc%0d: got evt=%b busy=%b done=%b cnt=%0d want %b %b %b %0d", i, b1.evt_out, b1.busy, b1.done, b1.sent_count, e.evt, e.busy, e.done, e.cnt);
      end
      step();
    end
    rst = 1;
    step();
    rst = 0;
    q.delete();
    repeat (3) push(0, 0, 0, 0);
    while (q.size() != 0) begin
      e = q.pop_front();
      checks++;
      if ({b1.evt_out, b1.busy, b1.done, b1.sent_count} !== e) begin
        errors++;
        $display("FAIL rst_mid: got evt=%b busy=%b done=%b cnt=%0d want %b %b %b %0d", b1.evt_out, b1.busy, b1.done, b1.sent_count, e.evt, e.busy, e.done, e.cnt);
      end
      step();
    end
  endtask

  task automatic test_cont_wrap();
    b2.cont = 1;
    b2.num_evt = 4'd1;
    b2.period = 24'd2;
    b2.width = 24'd1;
    for (int i = 0; i < 40; i++) push(i % 2 == 0, 1, 0, ((i / 2) + 1) % 16);
    repeat (3) push(0, 0, 0, 4);
    b2.start = 1;
    step();
    b2.start = 0;
    b2.cont = 0;
    for (int i = 0; i < 43; i++) begin
      e = q.pop_front();
      checks++;
      if ({b2.evt_out, b2.busy, b2.done, 12'd0, b2.sent_count} !== e) begin
        errors++;
        $display("FAIL cont_wrap cyc%0d: got evt=%b busy=%b done=%b cnt=%0d want %b %b %b %0d", i, b2.evt_out, b2.busy, b2.done, b2.sent_count, e.evt, e.busy, e.done, e.cnt);
      end
      if (i == 39) b2.abort = 1;
      step();
      b2.abort = 0;
    end
  endtask

  initial begin
    b1.start = 0; b1.abort = 0; b1.cont = 0; b1.num_evt = 0; b1.period = 0; b1.width = 0;
    b2.start = 0; b2.abort = 0; b2.cont = 0; b2.num_evt = 0; b2.period = 0; b2.width = 0;
    #1;
    test_reset();
    test_basic();
    test_clamp(2, 1, 0, 2, 1);
    test_clamp(2, 4, 7, 4, 3);
    test_zero();
    test_abort();
    test_start_abort();
    test_reset_mid();
    test_cont_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
